// File: rtl/led_shift_engine_pkg.sv
// led_shift_engine_pkg
//   Shared definitions for the LED shift engine:
//   - mode_e    : pattern step modes (HOLD / SHIFT / ROTATE / BOUNCE)
//   - DIR_LEFT  : step toward the MSB
//   - DIR_RIGHT : step toward the LSB
package led_shift_engine_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_shift_engine_if.sv
// led_shift_engine_if
//   Control and pattern signals of the LED shift engine.
//   master : tiks, en, dir, mode, load, load_pattern out; leds, step, wrap in
//   slave  : the engine side (mirror of master)
interface led_shift_engine_if #(
    parameter int WIDTH = 8
);
    import led_shift_engine_pkg::*;

    logic             tiks;
    logic             en;
    logic             dir;
    mode_e            mode;
    logic             load;
    logic [WIDTH-1:0] load_pattern;
    logic [WIDTH-1:0] leds;
    logic             step;
    logic             wrap;

    modport master (
        output tiks, en, dir, mode, load, load_pattern,
        input  leds, step, wrap
    );

    modport slave (
        input  tiks, en, dir, mode, load, load_pattern,
        output leds, step, wrap
    );

endinterface

// File: rtl/led_shift_engine_tick_edge_detect.sv
// tick_edge_detect
//   Turns the toggling tiks stream into a one-cycle event per toggle.
//   Ports:
//     clock : system clock
//     rst   : asynchronous active-low reset
//     tiks  : toggle stream, synchronous to clock
//     ev    : high for the cycle in which tiks differs from its previous value
module tick_edge_detect (
    input  logic clock,
    input  logic rst,
    input  logic tiks,
    output logic ev
);

    // Reset value 0 means a tiks already high at reset release counts as one event.
    logic tiks_d;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tiks_d <= 1'b0;
        end else begin
            tiks_d <= tiks;
        end
    end

    assign ev = tiks ^ tiks_d;

endmodule

// File: rtl/led_shift_engine.sv
// led_shift_engine
//   Advances an LED pattern by one position every DIV tick events
//   (one event per tiks toggle): logical shift, rotate or bounce.
//   Ports:
//     clock : system clock
//     rst   : asynchronous active-low reset
//     bus   : led_shift_engine_if.slave
//             in : tiks, en, dir, mode, load, load_pattern
//             out: leds (registered pattern), step/wrap (1-cycle pulses)
//   Configuration:
//     SHIFT_BOUNCE_EN defined   -> mode 11 bounces between the end bits.
//     SHIFT_BOUNCE_EN undefined -> mode 11 behaves as HOLD, no bounce direction register.
module led_shift_engine
    import led_shift_engine_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               DIV          = 1,
    parameter logic [WIDTH-1:0] INIT_PATTERN = WIDTH'(1)
) (
    input  logic               clock,
    input  logic               rst,
    led_shift_engine_if.slave  bus
);

    localparam int               CNT_W    = $clog2(DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic             ev;
    logic             do_step;
    logic [CNT_W-1:0] div_cnt;
    logic [WIDTH-1:0] leds_q;
    logic [WIDTH-1:0] leds_nxt;
    logic             step_q;
    logic             step_nxt;
    logic             wrap_q;
    logic             wrap_nxt;

    // Bit that leaves the pattern when stepping in direction d.
    function automatic logic end_bit(input logic [WIDTH-1:0] p, input logic d);
        return (d == DIR_LEFT) ? p[WIDTH-1] : p[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] p, input logic d);
        return (d == DIR_LEFT) ? {p[WIDTH-2:0], 1'b0} : {1'b0, p[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] rotate_one(input logic [WIDTH-1:0] p, input logic d);
        return (d == DIR_LEFT) ? {p[WIDTH-2:0], p[WIDTH-1]} : {p[0], p[WIDTH-1:1]};
    endfunction

    tick_edge_detect u_tick (
        .clock (clock),
        .rst   (rst),
        .tiks  (bus.tiks),
        .ev    (ev)
    );

    assign do_step = ev & bus.en & (div_cnt == CNT_LAST);

`ifdef SHIFT_BOUNCE_EN
    logic  bdir_q;
    logic  bdir_nxt;
    logic  bdir_eff;
    mode_e mode_q;
    logic  bounce_entry;

    // Entering BOUNCE takes the external direction; a step in the same cycle already uses it.
    assign bounce_entry = (bus.mode == MODE_BOUNCE) && (mode_q != MODE_BOUNCE);
    assign bdir_eff     = bounce_entry ? bus.dir : bdir_q;
`endif

    always_comb begin
        leds_nxt = leds_q;
        step_nxt = 1'b0;
        wrap_nxt = 1'b0;
`ifdef SHIFT_BOUNCE_EN
        bdir_nxt = bdir_eff;
`endif
        if (do_step) begin
            case (bus.mode)
                MODE_SHIFT: begin
                    leds_nxt = shift_one(leds_q, bus.dir);
                    step_nxt = 1'b1;
                    wrap_nxt = end_bit(leds_q, bus.dir);
                end
                MODE_ROTATE: begin
                    leds_nxt = rotate_one(leds_q, bus.dir);
                    step_nxt = 1'b1;
                    wrap_nxt = end_bit(leds_q, bus.dir);
                end
`ifdef SHIFT_BOUNCE_EN
                MODE_BOUNCE: begin
                    step_nxt = 1'b1;
                    // All-zero pattern has nothing to bounce: hold, no wrap.
                    if (leds_q != '0) begin
                        if (end_bit(leds_q, bdir_eff)) begin
                            bdir_nxt = ~bdir_eff;
                            wrap_nxt = 1'b1;
                            // With both end bits set the pattern cannot move either way.
                            if (!end_bit(leds_q, ~bdir_eff)) begin
                                leds_nxt = shift_one(leds_q, ~bdir_eff);
                            end
                        end else begin
                            leds_nxt = shift_one(leds_q, bdir_eff);
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            leds_q  <= INIT_PATTERN;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            div_cnt <= '0;
`ifdef SHIFT_BOUNCE_EN
            bdir_q  <= DIR_LEFT;
            mode_q  <= MODE_HOLD;
`endif
        end else begin
`ifdef SHIFT_BOUNCE_EN
            mode_q <= bus.mode;
`endif
            // load wins over a coincident step, which is dropped.
            if (bus.load) begin
                leds_q  <= bus.load_pattern;
                step_q  <= 1'b0;
                wrap_q  <= 1'b0;
                div_cnt <= '0;
`ifdef SHIFT_BOUNCE_EN
                bdir_q  <= bus.dir;
`endif
            end else begin
                leds_q <= leds_nxt;
                step_q <= step_nxt;
                wrap_q <= wrap_nxt;
`ifdef SHIFT_BOUNCE_EN
                bdir_q <= bdir_nxt;
`endif
                if (ev && bus.en) begin
                    div_cnt <= do_step ? '0 : div_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.leds = leds_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;

endmodule
